param_load_ctrl: RTL and testbench

PARAM_LOAD_CTRL -- requirements
Module: param_load_ctrl

---
 rtl/param_load_ctrl_pkg.sv | 25 ++
 rtl/param_load_ctrl.sv | 118 +++++++++++
 tb/tb_param_load_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_load_ctrl_pkg.sv
// Shared types and helpers for the parameter loader and its buffers.
// Holds the loader state encoding and the constant-width helpers.
package param_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_DONE   = 2'd3
  } plc_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/param_load_ctrl.sv
// Streams W_SIZE weight words then B_SIZE bias words into buffers.
// Ports: clk/global_rst_n, i_start/i_abort, i_valid/i_data in; o_ready, o_data, o_w_ce/o_b_ce, o_busy, o_done, o_cnt out.
module param_load_ctrl
  import param_load_ctrl_pkg::*;
#(
  parameter int BW     = 16,
  parameter int W_SIZE = 150,
  parameter int B_SIZE = 6,
  localparam int CW    = clog2(max2(W_SIZE, B_SIZE) + 1)
) (
  input  logic          clk,
  input  logic          global_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_valid,
  input  logic [BW-1:0] i_data,
  output logic          o_ready,
  output logic [BW-1:0] o_data,
  output logic          o_w_ce,
  output logic          o_b_ce,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_cnt
);

  localparam logic [CW-1:0] W_LAST = CW'(W_SIZE - 1);
  localparam logic [CW-1:0] B_LAST = CW'(B_SIZE - 1);

  plc_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] data_q, data_d;
  logic          w_ce_q, w_ce_d;
  logic          b_ce_q, b_ce_d;
  logic          done_q, done_d;
  logic          beat;

  assign o_ready = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B);
  assign o_busy  = (state_q != ST_IDLE);
  assign beat    = i_valid & o_ready;

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      w_ce_q  <= 1'b0;
      b_ce_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      w_ce_q  <= w_ce_d;
      b_ce_q  <= b_ce_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    w_ce_d  = 1'b0;
    b_ce_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        if (beat) begin
          data_d = i_data;
          w_ce_d = 1'b1;
          if (cnt_q == W_LAST) begin
            cnt_d   = '0;
            state_d = ST_LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD_B: begin
        if (beat) begin
          data_d = i_data;
          b_ce_d = 1'b1;
          if (cnt_q == B_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // o_done trails DONE by a cycle so it follows the last bias strobe.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort drops the in-flight beat entirely, including its strobe.
    if (i_abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      data_d  = data_q;
      w_ce_d  = 1'b0;
      b_ce_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign o_data = data_q;
  assign o_w_ce = w_ce_q;
  assign o_b_ce = b_ce_q;
  assign o_done = done_q;
  assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_param_load_ctrl.sv
// Self-checking bench for param_load_ctrl (25/6 and 1/1 configurations).
// Cycle-level word-count model plus a vector table for the 1/1 instance.
module tb_param_load_ctrl;

  localparam int BW  = 16;
  localparam int W   = 25;
  localparam int B   = 6;
  localparam int CWA = $clog2(W + 1);
  localparam int CWB = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           a_start, a_abort, a_valid;
  logic [BW-1:0]  a_data_i;
  logic           a_ready, a_w_ce, a_b_ce, a_busy, a_done;
  logic [BW-1:0]  a_data_o;
  logic [CWA-1:0] a_cnt;

  logic           b_start, b_abort, b_valid;
  logic [BW-1:0]  b_data_i;
  logic           b_ready, b_w_ce, b_b_ce, b_busy, b_done;
  logic [BW-1:0]  b_data_o;
  logic [CWB-1:0] b_cnt;

  param_load_ctrl #(.BW(BW), .W_SIZE(W), .B_SIZE(B)) u_a (
    .clk(clk), .global_rst_n(rst_n),
    .i_start(a_start), .i_abort(a_abort),
    .i_valid(a_valid), .i_data(a_data_i),
    .o_ready(a_ready), .o_data(a_data_o),
    .o_w_ce(a_w_ce), .o_b_ce(a_b_ce),
    .o_busy(a_busy), .o_done(a_done), .o_cnt(a_cnt)
  );

  param_load_ctrl #(.BW(BW), .W_SIZE(1), .B_SIZE(1)) u_b (
    .clk(clk), .global_rst_n(rst_n),
    .i_start(b_start), .i_abort(b_abort),
    .i_valid(b_valid), .i_data(b_data_i),
    .o_ready(b_ready), .o_data(b_data_o),
    .o_w_ce(b_w_ce), .o_b_ce(b_b_ce),
    .o_busy(b_busy), .o_done(b_done), .o_cnt(b_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wcnt, bcnt, dcnt, done_cyc, start_cyc;

  // Model: words accepted so far in this load, and where we are in it.
  bit            m_load, m_tail, m_done, m_wce, m_bce, m_beat;
  int            m_n;
  logic [BW-1:0] m_data;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_tail = 0; m_done = 0;
    m_wce = 0; m_bce = 0; m_beat = 0;
    m_n = 0; m_data = '0;
  endtask

  task automatic model_edge();
    bit new_tail;
    new_tail = 0;
    m_beat = 0; m_wce = 0; m_bce = 0;
    m_done = m_tail && !a_abort;
    if (a_abort) begin
      m_load = 0;
      m_n = 0;
    end else if (m_load) begin
      if (a_valid) begin
        m_beat = 1;
        m_data = a_data_i;
        if (m_n < W) m_wce = 1;
        else m_bce = 1;
        m_n++;
        if (m_n == W + B) begin
          m_load = 0;
          m_n = 0;
          new_tail = 1;
        end
      end
    end else if (!m_tail && a_start) begin
      m_load = 1;
    end
    m_tail = new_tail;
  endtask

  task automatic step();
    int ecnt;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    ecnt = !m_load ? 0 : (m_n < W ? m_n : m_n - W);
    chk("a_ready", 32'(a_ready), 32'(m_load));
    chk("a_busy", 32'(a_busy), 32'(m_load | m_tail));
    chk("a_w_ce", 32'(a_w_ce), 32'(m_wce));
    chk("a_b_ce", 32'(a_b_ce), 32'(m_bce));
    chk("a_done", 32'(a_done), 32'(m_done));
    chk("a_cnt", 32'(a_cnt), 32'(ecnt));
    chk("a_data", 32'(a_data_o), 32'(m_data));
    if (a_w_ce) wcnt++;
    if (a_b_ce) bcnt++;
    if (a_done) begin
      dcnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clr_counts();
    wcnt = 0; bcnt = 0; dcnt = 0; done_cyc = -1;
  endtask

  // mode 0: valid held, 1: valid toggling, 2: random valid/data/abort
  task automatic load(input int mode, input int start_at);
    int word;
    bit fin;
    word = 1;
    fin = 0;
    clr_counts();
    a_start = 1;
    a_valid = (mode == 0);
    a_data_i = 16'(word);
    start_cyc = cyc;
    step();
    a_start = 0;
    for (int k = 0; k < 400; k++) begin
      case (mode)
        0: a_valid = 1;
        1: a_valid = (k % 2 == 0);
        default: a_valid = 1'($urandom_range(1, 0));
      endcase
      a_abort = (mode == 2) && ($urandom_range(59, 0) == 0);
      a_start = (start_at >= 0) && m_load && (m_n == start_at);
      a_data_i = (mode == 2) ? 16'($urandom) : 16'(word);
      step();
      if (m_beat) word++;
      if (m_done || (!m_load && !m_tail)) begin
        fin = 1;
        break;
      end
    end
    a_valid = 0;
    a_start = 0;
    a_abort = 0;
    chk("load_finished", 32'(fin), 32'd1);
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_ready"}, 32'(a_ready), 0);
    chk({tag, "_busy"}, 32'(a_busy), 0);
    chk({tag, "_wce"}, 32'(a_w_ce), 0);
    chk({tag, "_bce"}, 32'(a_b_ce), 0);
    chk({tag, "_done"}, 32'(a_done), 0);
    chk({tag, "_cnt"}, 32'(a_cnt), 0);
    chk({tag, "_data"}, 32'(a_data_o), 0);
  endtask

  typedef struct {
    bit st, vl, ab;
    logic [BW-1:0] d;
    bit rdy, bsy, wce, bce, dn;
    logic [BW-1:0] od;
    bit cd;
  } vec_t;

  initial begin
    vec_t tv[15];
    int word;
    a_start = 0; a_abort = 0; a_valid = 0; a_data_i = '0;
    b_start = 0; b_abort = 0; b_valid = 0; b_data_i = '0;
    model_reset();
    clr_counts();
    rst_n = 0;
    #3;
    chk_a_zero("rst_a");
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_b_data", 32'(b_data_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    //        st vl ab d         rdy bsy wce bce dn od        cd
    tv[0]  = '{1, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 1};
    tv[1]  = '{0, 1, 0, 16'h0011, 1, 1, 1, 0, 0, 16'h0011, 1};
    tv[2]  = '{0, 1, 0, 16'h0022, 0, 1, 0, 1, 0, 16'h0022, 1};
    tv[3]  = '{0, 1, 0, 16'h0033, 0, 0, 0, 0, 1, 16'h0022, 1};
    tv[4]  = '{0, 1, 0, 16'h00aa, 0, 0, 0, 0, 0, 16'h0022, 1};
    tv[5]  = '{1, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 16'h0022, 1};
    tv[6]  = '{1, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0022, 1};
    tv[7]  = '{0, 1, 1, 16'h0044, 0, 0, 0, 0, 0, 16'h0000, 0};
    tv[8]  = '{0, 1, 0, 16'h00bb, 0, 0, 0, 0, 0, 16'h0000, 0};
    tv[9]  = '{1, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 0};
    tv[10] = '{0, 1, 0, 16'h0055, 1, 1, 1, 0, 0, 16'h0055, 1};
    tv[11] = '{1, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0055, 1};
    tv[12] = '{0, 1, 0, 16'h0066, 0, 1, 0, 1, 0, 16'h0066, 1};
    tv[13] = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0066, 1};
    tv[14] = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0066, 1};

    for (int i = 0; i < 15; i++) begin
      b_start = tv[i].st;
      b_valid = tv[i].vl;
      b_abort = tv[i].ab;
      b_data_i = tv[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(b_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_busy", i), 32'(b_busy), 32'(tv[i].bsy));
      chk($sformatf("v%0d_wce", i), 32'(b_w_ce), 32'(tv[i].wce));
      chk($sformatf("v%0d_bce", i), 32'(b_b_ce), 32'(tv[i].bce));
      chk($sformatf("v%0d_done", i), 32'(b_done), 32'(tv[i].dn));
      chk($sformatf("v%0d_cnt", i), 32'(b_cnt), 0);
      if (tv[i].cd)
        chk($sformatf("v%0d_data", i), 32'(b_data_o), 32'(tv[i].od));
    end
    b_start = 0; b_valid = 0; b_abort = 0;

    // Full load, valid held high.
    load(0, -1);
    chk("full_w", wcnt, W);
    chk("full_b", bcnt, B);
    chk("full_done", dcnt, 1);
    chk("full_done_lat", done_cyc - start_cyc, 33);

    // Valid toggling.
    load(1, -1);
    chk("tog_w", wcnt, W);
    chk("tog_b", bcnt, B);
    chk("tog_done", dcnt, 1);

    // Start pulsed while loading bias words.
    load(0, W + 2);
    chk("stb_w", wcnt, W);
    chk("stb_b", bcnt, B);
    chk("stb_done", dcnt, 1);

    // Abort after the 10th weight beat.
    clr_counts();
    a_start = 1;
    a_valid = 1;
    step();
    a_start = 0;
    word = 1;
    for (int k = 0; k < 40; k++) begin
      a_data_i = 16'(word);
      a_abort = m_load && (m_n == 10);
      step();
      if (m_beat) word++;
      if (!m_load) break;
    end
    a_abort = 0;
    a_valid = 0;
    chk("abt_busy", 32'(a_busy), 0);
    step();
    step();
    chk("abt_w", wcnt, 10);
    chk("abt_b", bcnt, 0);
    chk("abt_done", dcnt, 0);
    load(0, -1);
    chk("reload_w", wcnt, W);
    chk("reload_b", bcnt, B);
    chk("reload_done", dcnt, 1);

    // Reset in the middle of weight beat 12.
    a_start = 1;
    a_valid = 1;
    step();
    a_start = 0;
    word = 1;
    for (int k = 0; k < 40; k++) begin
      a_data_i = 16'(word);
      step();
      if (m_beat) word++;
      if (m_n == 11) break;
    end
    a_valid = 1;
    #2;
    rst_n = 0;
    #1;
    chk_a_zero("amid");
    a_valid = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    load(0, -1);
    chk("postrst_w", wcnt, W);
    chk("postrst_b", bcnt, B);
    chk("postrst_done", dcnt, 1);

    // Random traffic with occasional aborts.
    for (int r = 0; r < 12; r++) begin
      load(2, -1);
      repeat ($urandom_range(3, 0)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
